// File: rtl/hamming_link_ctrl.sv
// (7,4) Hamming serial link controller: TX collect/encode/serialize, RX frame/decode/correct; HAMM_LOOPBACK_EN adds loopback.
// Latency: 4th TX bit accepted -> first line bit 2 cycles later; 7th RX bit -> dec_vld 2 cycles later.
// Backpressure: ser_rdy drops while the TX nibble hold is full; an unconsumed dec_data is overwritten and flags rx_ovf.
module hamming_link_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef HAMM_LOOPBACK_EN
  input  logic             loopback,
`endif
  input  logic             ser_in,
  input  logic             ser_vld,
  output logic             ser_rdy,
  output logic             line_out,
  output logic             line_vld,
  output logic             line_sof,
  input  logic             line_in,
  input  logic             line_ivld,
  input  logic             line_isof,
  output logic [3:0]       dec_data,
  output logic             dec_vld,
  input  logic             dec_rdy,
  output logic [2:0]       err_idx,
  output logic             rx_ovf,
  output logic             sync_err,
  output logic [CNT_W-1:0] corr_cnt
);

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] idx;
  } dec_t;

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  function automatic logic [6:0] hamm_enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Only the data positions are ever corrected; parity bits are not delivered.
  function automatic dec_t hamm_dec(input logic [6:0] c);
    dec_t       r;
    logic [2:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    r.data[3] = c[6] ^ (s == 3'd7);
    r.data[2] = c[5] ^ (s == 3'd6);
    r.data[1] = c[4] ^ (s == 3'd5);
    r.data[0] = c[2] ^ (s == 3'd3);
    r.idx     = s;
    return r;
  endfunction

  // ---------------- TX collector ----------------
  logic [1:0] col_cnt;
  logic [2:0] col_sr;
  logic [3:0] hold_nib;
  logic       hold_full;
  logic       ser_acc;
  logic       hold_set;
  logic       hold_clr;
  tx_state_t  tx_state;
  logic [6:0] tx_sr;
  logic [2:0] tx_cnt;

  assign ser_rdy  = ~hold_full;
  assign ser_acc  = ser_vld & ser_rdy;
  assign hold_set = ser_acc & (col_cnt == 2'd3);
  assign hold_clr = hold_full & ((tx_state == TX_IDLE) | (tx_cnt == 3'd6));
  assign line_out = tx_sr[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= 2'd0;
      col_sr    <= 3'd0;
      hold_nib  <= 4'd0;
      hold_full <= 1'b0;
    end else begin
      if (ser_acc) begin
        col_cnt <= col_cnt + 2'd1;
        col_sr  <= {col_sr[1:0], ser_in};
      end
      if (hold_set) begin
        hold_nib  <= {col_sr, ser_in};
        hold_full <= 1'b1;
      end else if (hold_clr) begin
        hold_full <= 1'b0;
      end
    end
  end

  // ---------------- TX serializer FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_sr    <= 7'd0;
      tx_cnt   <= 3'd0;
      line_vld <= 1'b0;
      line_sof <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (hold_full) begin
            tx_sr    <= hamm_enc(hold_nib);
            tx_cnt   <= 3'd0;
            line_vld <= 1'b1;
            line_sof <= 1'b1;
            tx_state <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt == 3'd6) begin
            if (hold_full) begin
              // Next nibble already waiting: start its frame without an idle cycle.
              tx_sr    <= hamm_enc(hold_nib);
              tx_cnt   <= 3'd0;
              line_sof <= 1'b1;
            end else begin
              tx_sr    <= 7'd0;
              tx_cnt   <= 3'd0;
              line_vld <= 1'b0;
              line_sof <= 1'b0;
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_sr    <= {tx_sr[5:0], 1'b0};
            tx_cnt   <= tx_cnt + 3'd1;
            line_sof <= 1'b0;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX framer ----------------
  logic       rx_bit;
  logic       rx_vld;
  logic       rx_sof;
  rx_state_t  rx_state;
  logic [5:0] rx_sr;
  logic [2:0] rx_cnt;
  logic [6:0] rx_cw;
  logic       rx_done;
  dec_t       dec_nxt;

`ifdef HAMM_LOOPBACK_EN
  assign rx_bit = loopback ? line_out : line_in;
  assign rx_vld = loopback ? line_vld : line_ivld;
  assign rx_sof = loopback ? line_sof : line_isof;
`else
  assign rx_bit = line_in;
  assign rx_vld = line_ivld;
  assign rx_sof = line_isof;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_sr    <= 6'd0;
      rx_cnt   <= 3'd0;
      rx_cw    <= 7'd0;
      rx_done  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      rx_done  <= 1'b0;
      sync_err <= 1'b0;
      if (rx_vld) begin
        if (rx_sof) begin
          // sof always restarts framing, dropping any partial frame.
          rx_sr    <= {5'd0, rx_bit};
          rx_cnt   <= 3'd1;
          rx_state <= RX_RECV;
        end else if (rx_state == RX_RECV) begin
          if (rx_cnt == 3'd6) begin
            rx_cw    <= {rx_sr, rx_bit};
            rx_done  <= 1'b1;
            rx_cnt   <= 3'd0;
            rx_state <= RX_IDLE;
          end else begin
            rx_sr  <= {rx_sr[4:0], rx_bit};
            rx_cnt <= rx_cnt + 3'd1;
          end
        end else begin
          sync_err <= 1'b1;
        end
      end
    end
  end

  // ---------------- RX decode / output hold ----------------
  assign dec_nxt = hamm_dec(rx_cw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_data <= 4'd0;
      err_idx  <= 3'd0;
      dec_vld  <= 1'b0;
      rx_ovf   <= 1'b0;
      corr_cnt <= '0;
    end else begin
      if (rx_done) begin
        dec_data <= dec_nxt.data;
        err_idx  <= dec_nxt.idx;
        dec_vld  <= 1'b1;
        if (dec_vld && !dec_rdy) rx_ovf <= 1'b1;
        if ((dec_nxt.idx != 3'd0) && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
      end else if (dec_rdy) begin
        dec_vld <= 1'b0;
      end
    end
  end

endmodule
